id_hazard_ctrl: RTL
===================

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of both saturating performance counters.
REQ-002 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 IF_ID_Rs, IF_ID_Rt  in  5 each  source registers of the instruction in ID.
REQ-005 ID_UsesRt  in  1  ID instruction reads Rt; ID_Branch  in  1  ID instruction resolves a branch or jr in ID.
REQ-006 ID_EX_Rd  in  5, ID_EX_RegWrite  in  1, ID_EX_MemRead  in  1  destination and type of the instruction in EX.
REQ-007 EX_MEM_Rd  in  5, EX_MEM_RegWrite  in  1, EX_MEM_MemRead  in  1  destination and type of the instruction in MEM.
REQ-008 Branch_Taken  in  1, Jump  in  1  redirect decided in ID this cycle.
REQ-009 Perf_Clear  in  1  synchronous clear of both counters.
REQ-010 PC_Write  out  1, IF_ID_Write  out  1  PC and IF/ID enables, 0 = hold.
REQ-011 IF_ID_Flush  out  1  squash the IF/ID instruction; ID_EX_Flush  out  1  insert a bubble into ID/EX.
REQ-012 Stall_Cycles  out  CNT_W, Flush_Count  out  CNT_W  performance counters.

Function
REQ-013 match(R, X) SHALL be true when R != 0 and R == X; register 0 never causes a hazard.
REQ-014 Rt-side matches SHALL count only when ID_UsesRt = 1.
REQ-015 Hazard LU (load-use, 1 cycle): ID_EX_MemRead and ID_EX_Rd matches Rs or Rt, ID_Branch = 0.
REQ-016 Hazard BL (branch on load in EX, 2 cycles): ID_Branch, ID_EX_MemRead, ID_EX_Rd matches Rs or Rt.
REQ-017 Hazard BA (branch on ALU result in EX, 1 cycle): ID_Branch, ID_EX_RegWrite, !ID_EX_MemRead, ID_EX_Rd matches Rs or Rt.
REQ-018 Hazard BM (1 cycle): ID_Branch and either EX_MEM_MemRead with EX_MEM_Rd matching Rs/Rt, or EX_MEM_RegWrite with EX_MEM_Rd matching Rt (Rt has no EX/MEM forward path in ID).
REQ-019 FSM states: RUN, HOLD; reset state RUN.
REQ-020 In RUN, stall = LU | BL | BA | BM, evaluated combinationally in the same cycle (Mealy).
REQ-021 RUN -> HOLD on BL; all other cases stay in RUN.
REQ-022 In HOLD, stall = 1 unconditionally; HOLD -> RUN on the next edge.
REQ-023 When stall = 1: PC_Write = 0, IF_ID_Write = 0, ID_EX_Flush = 1, IF_ID_Flush = 0.
REQ-024 When stall = 0: PC_Write = 1, IF_ID_Write = 1, ID_EX_Flush = 0, IF_ID_Flush = Branch_Taken | Jump.
REQ-025 Stall has priority over redirect; Branch_Taken/Jump during a stall cycle SHALL be ignored.
REQ-026 Stall_Cycles SHALL increment by 1 on each edge where stall = 1; Flush_Count on each edge where IF_ID_Flush = 1.
REQ-027 Both counters SHALL saturate at 2^CNT_W - 1 and never wrap.
REQ-028 Perf_Clear SHALL zero both counters on the edge, taking priority over a simultaneous increment.

Reset
REQ-029 rst_n = 0 SHALL immediately force state RUN and both counters to 0, independent of clk.
REQ-030 While rst_n = 0: PC_Write = 1, IF_ID_Write = 1, IF_ID_Flush = 0, ID_EX_Flush = 0.
REQ-031 Reset asserted in HOLD SHALL abandon the stall; after deassertion, evaluation restarts in RUN.

Structure
REQ-032 The state encoding (RUN = 1'b0, HOLD = 1'b1) and the hazard-class constants SHALL live in the shared pipeline package.
REQ-033 The counters SHALL be two instances of a sub-module sat_counter (parameter W; inputs clk, rst_n, clr, inc; output count).

Verification
REQ-034 lw $8 in EX (ID_EX_MemRead = 1, Rd = 8), add in ID reading Rs = 8 -> PC_Write = 0 and ID_EX_Flush = 1 for exactly 1 cycle; Stall_Cycles = 1.
REQ-035 lw $9 in EX, beq $9,$3 in ID (ID_Branch = 1, ID_UsesRt = 1) -> 2 consecutive stall cycles (RUN, HOLD, RUN); Stall_Cycles = 2.
REQ-036 EX_MEM_RegWrite = 1, EX_MEM_Rd = 5, beq $2,$5 in ID -> 1 stall; same with Rs = 5 and Rt unrelated -> no stall.
REQ-037 ID_EX_MemRead = 1, ID_EX_Rd = 0, Rs = 0 -> no stall; then Jump = 1 -> IF_ID_Flush = 1 and Flush_Count = 1.
REQ-038 CNT_W = 4, 20 stall cycles -> Stall_Cycles holds 15; Perf_Clear together with a stall -> 0.
REQ-039 rst_n low during HOLD -> outputs take their reset values immediately; the cycle after release with no hazard -> PC_Write = 1.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl_pkg
// Purpose  : Shared pipeline definitions for the ID-stage hazard controller.
//            Holds the stall FSM state encoding, hazard-class bit positions
//            and the register-match helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package id_hazard_ctrl_pkg;

    // Stall FSM: RUN evaluates hazards, HOLD is the forced second stall cycle
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Hazard-class bit positions inside the hazard vector
    localparam int HZ_LU  = 0;  // load-use, non-branch consumer
    localparam int HZ_BL  = 1;  // branch waiting on a load in EX (2 cycles)
    localparam int HZ_BA  = 2;  // branch waiting on an ALU result in EX
    localparam int HZ_BM  = 3;  // branch waiting on MEM (load, or Rt producer)
    localparam int HZ_NUM = 4;

    // Register 0 is hard-wired to zero and never creates a dependency
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] x);
        return (r != 5'd0) && (r == x);
    endfunction

endpackage : id_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/id_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl_if
// Purpose  : Bundle of pipeline-status inputs and stall/flush outputs of the
//            ID hazard controller.
// Ports    : master - pipeline side (drives status, receives controls)
//            slave  - hazard controller side
// Revision : 1.0  initial release
// ============================================================================
interface id_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_Rs;
    logic [4:0]       IF_ID_Rt;
    logic             ID_UsesRt;
    logic             ID_Branch;
    logic [4:0]       ID_EX_Rd;
    logic             ID_EX_RegWrite;
    logic             ID_EX_MemRead;
    logic [4:0]       EX_MEM_Rd;
    logic             EX_MEM_RegWrite;
    logic             EX_MEM_MemRead;
    logic             Branch_Taken;
    logic             Jump;
    logic             Perf_Clear;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic [CNT_W-1:0] Stall_Cycles;
    logic [CNT_W-1:0] Flush_Count;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_Branch,
               ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead,
               EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemRead,
               Branch_Taken, Jump, Perf_Clear,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
               Stall_Cycles, Flush_Count
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_Branch,
               ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead,
               EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_MemRead,
               Branch_Taken, Jump, Perf_Clear,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
               Stall_Cycles, Flush_Count
    );
endinterface : id_hazard_ctrl_if
`default_nettype wire

// File: rtl/id_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous clear.
// Ports    : clk, rst_n (async, active low), clr (sync clear, wins over inc),
//            inc (count enable), count (current value, sticks at all-ones)
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic      [W-1:0] count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
endmodule : sat_counter
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_ctrl
// Purpose  : ID-stage hazard detection for a 5-stage pipeline with branch
//            resolution in ID. Detects load-use and branch-operand hazards,
//            stalls PC and IF/ID, inserts ID/EX bubbles, squashes IF/ID on
//            redirects and counts stall and flush cycles.
// Ports    : clk, rst_n (async, active low)
//            hz : id_hazard_ctrl_if.slave (pipeline status in, controls and
//                 performance counters out)
// Revision : 1.0  initial release
// ============================================================================
module id_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    id_hazard_ctrl_if.slave hz
);
    import id_hazard_ctrl_pkg::*;

    logic              ex_src;      // ID source depends on EX destination
    logic              mem_src;     // ID source depends on MEM destination
    logic              mem_rt;      // Rt depends on MEM destination
    logic [HZ_NUM-1:0] hz_vec;
    state_t            r_state;
    state_t            state_next;
    logic              stall_raw;
    logic              stall;
    logic              flush_if;

    assign ex_src  = reg_match(hz.IF_ID_Rs, hz.ID_EX_Rd)
                   | (hz.ID_UsesRt & reg_match(hz.IF_ID_Rt, hz.ID_EX_Rd));
    assign mem_rt  = hz.ID_UsesRt & reg_match(hz.IF_ID_Rt, hz.EX_MEM_Rd);
    assign mem_src = reg_match(hz.IF_ID_Rs, hz.EX_MEM_Rd) | mem_rt;

    always_comb begin
        hz_vec         = '0;
        hz_vec[HZ_LU]  = hz.ID_EX_MemRead & ex_src & ~hz.ID_Branch;
        hz_vec[HZ_BL]  = hz.ID_Branch & hz.ID_EX_MemRead & ex_src;
        hz_vec[HZ_BA]  = hz.ID_Branch & hz.ID_EX_RegWrite & ~hz.ID_EX_MemRead & ex_src;
        // ALU results in MEM forward into ID on Rs only; Rt must wait
        hz_vec[HZ_BM]  = hz.ID_Branch & ((hz.EX_MEM_MemRead & mem_src)
                                       | (hz.EX_MEM_RegWrite & mem_rt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= state_next;
        end
    end

    always_comb begin
        state_next = r_state;
        stall_raw  = 1'b0;
        case (r_state)
            ST_RUN: begin
                stall_raw = |hz_vec;
                if (hz_vec[HZ_BL]) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                stall_raw  = 1'b1;
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Hazards seen while reset is held must not freeze the front end
    assign stall    = stall_raw & rst_n;
    // A stalled redirect is re-presented once the stall clears
    assign flush_if = ~stall & rst_n & (hz.Branch_Taken | hz.Jump);

    assign hz.PC_Write    = ~stall;
    assign hz.IF_ID_Write = ~stall;
    assign hz.ID_EX_Flush = stall;
    assign hz.IF_ID_Flush = flush_if;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hz.Perf_Clear),
        .inc   (stall),
        .count (hz.Stall_Cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hz.Perf_Clear),
        .inc   (flush_if),
        .count (hz.Flush_Count)
    );
endmodule : id_hazard_ctrl
`default_nettype wire
